// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared beat type and width helpers for the packet FIFO
package axis_pkg;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_WIDTH = 8;

    typedef struct packed {
        logic                 last;
        logic [DEF_WIDTH-1:0] data;
    } beat_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy needs one extra bit so that "full" (== DEPTH) is representable.
    function automatic int lvl_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x WORD_W array, synchronous write, asynchronous read
module fifo_ram #(
    parameter int DEPTH  = 16,
    parameter int WORD_W = 9,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// rtl/axis_pkt_fifo.sv - first-word-fall-through stream FIFO, cut-through or store-and-forward
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PKT_MODE = 0,
    parameter int AF_LVL   = DEPTH - 2,
    parameter int AE_LVL   = 2
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic [WIDTH-1:0]        S_TData,
    input  logic                    S_TValid,
    input  logic                    S_TLast,
    output logic                    S_TReady,
    output logic [WIDTH-1:0]        M_TData,
    output logic                    M_TValid,
    output logic                    M_TLast,
    input  logic                    M_TReady,
    input  logic                    Flush,
    output logic                    isEmpty,
    output logic                    isFull,
    output logic [$clog2(DEPTH):0]  Level,
    output logic                    AlmostFull,
    output logic                    AlmostEmpty,
    output logic [$clog2(DEPTH):0]  PktCount,
    output logic                    Overrun
);

    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);
    localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L   = LW'(AF_LVL);
    localparam logic [LW-1:0] AE_L   = LW'(AE_LVL);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d, pkt_q, pkt_d;
    logic          release_q, release_d;
    logic          overrun_q, overrun_d;
    logic          af_q, af_d, ae_q, ae_d;
    logic          is_empty, is_full, m_valid, wr_beat, rd_beat, oversize;
    logic [WIDTH:0] rd_word;

    fifo_ram #(
        .DEPTH  (DEPTH),
        .WORD_W (WIDTH + 1),
        .AW     (PW)
    ) u_ram (
        .CLK     (CLK),
        .we_i    (wr_beat),
        .waddr_i (wr_ptr_q),
        .wdata_i ({S_TLast, S_TData}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_word)
    );

    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == FULL_L);
    // A full FIFO holding no TLast can never complete a packet; let it stream.
    assign oversize = (PKT_MODE != 0) && is_full && (pkt_q == '0);
    assign m_valid  = (PKT_MODE != 0) ? (!is_empty && ((pkt_q != '0) || release_q)) : !is_empty;
    assign wr_beat  = S_TValid && !is_full;
    assign rd_beat  = m_valid && M_TReady;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        pkt_d     = pkt_q;
        release_d = release_q;
        overrun_d = overrun_q | oversize;
        if (Flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            pkt_d     = '0;
            release_d = 1'b0;
        end else begin
            if (wr_beat) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_beat) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_beat, rd_beat})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            case ({wr_beat && S_TLast, rd_beat && rd_word[WIDTH]})
                2'b10:   pkt_d = pkt_q + LW'(1);
                2'b01:   pkt_d = pkt_q - LW'(1);
                default: pkt_d = pkt_q;
            endcase
            if (rd_beat && rd_word[WIDTH]) begin
                release_d = 1'b0;
            end else if (oversize) begin
                release_d = 1'b1;
            end
        end
        af_d = (level_d >= AF_L);
        ae_d = (level_d <= AE_L);
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pkt_q     <= '0;
            release_q <= 1'b0;
            overrun_q <= 1'b0;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pkt_q     <= pkt_d;
            release_q <= release_d;
            overrun_q <= overrun_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
        end
    end

    assign S_TReady    = !is_full;
    assign M_TData     = rd_word[WIDTH-1:0];
    assign M_TLast     = rd_word[WIDTH];
    assign M_TValid    = m_valid;
    assign isEmpty     = is_empty;
    assign isFull      = is_full;
    assign Level       = level_q;
    assign PktCount    = pkt_q;
    assign AlmostFull  = af_q;
    assign AlmostEmpty = ae_q;
    assign Overrun     = overrun_q;

endmodule

// File: doc/axis_pkt_fifo.md
AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 Parameter DEPTH, 16, number of entries; the value SHALL be a power of two and at least 2.
REQ-002 Parameter WIDTH, 8, TData bit width.
REQ-003 Parameter PKT_MODE, 0, selects the mode: 0 is cut-through, 1 is store-and-forward.
REQ-004 Parameter AF_LVL, DEPTH-2, level at or above which AlmostFull asserts.
REQ-005 Parameter AE_LVL, 2, level at or below which AlmostEmpty asserts.
REQ-006 CLK  in  1  clock; all logic SHALL be rising-edge synchronous.
REQ-007 Reset  in  1  synchronous, active-low reset.
REQ-008 S_TData  in  WIDTH  write-side data.
REQ-009 S_TValid, S_TLast  in  1 each  write-side valid and end-of-packet.
REQ-010 S_TReady  out  1  write-side ready.
REQ-011 M_TData  out  WIDTH  read-side data.
REQ-012 M_TValid, M_TLast  out  1 each  read-side valid and end-of-packet.
REQ-013 M_TReady  in  1  read-side ready.
REQ-014 Flush  in  1  synchronous clear of all stored content.
REQ-015 isEmpty, isFull  out  1 each  occupancy is 0, occupancy is DEPTH.
REQ-016 Level  out  $clog2(DEPTH)+1  current occupancy.
REQ-017 AlmostFull, AlmostEmpty  out  1 each  threshold flags.
REQ-018 PktCount  out  $clog2(DEPTH)+1  number of complete packets (TLast beats) stored.
REQ-019 Overrun  out  1  sticky flag, packet mode only.

Function
REQ-020 A write beat SHALL occur when S_TValid and S_TReady are both 1; a read beat SHALL occur when M_TValid and M_TReady are both 1.
REQ-021 S_TReady SHALL equal !isFull and SHALL NOT depend combinationally on M_TReady.
REQ-022 The FIFO SHALL be first-word-fall-through: a beat written on edge N SHALL be visible on M_TData/M_TLast in the cycle after edge N, provided it is at the head; there is no empty-to-output bypass.
REQ-023 Level SHALL increment by 1 on write-only, decrement by 1 on read-only, and stay unchanged on a simultaneous read and write.
REQ-024 Pointers SHALL be $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-025 AlmostFull SHALL be (Level >= AF_LVL); AlmostEmpty SHALL be (Level <= AE_LVL); both SHALL be registered consistently with Level.
REQ-026 PktCount SHALL increment on a write beat with S_TLast=1 and decrement on a read beat with M_TLast=1; when both happen in the same cycle it SHALL stay unchanged.
REQ-027 With PKT_MODE=0, M_TValid SHALL equal !isEmpty.
REQ-028 With PKT_MODE=1, M_TValid SHALL equal !isEmpty && (PktCount>0 || release), so M_TValid first asserts the cycle after the TLast beat is written.
REQ-029 release SHALL set when isFull && PktCount==0 (a packet larger than DEPTH); on that event Overrun SHALL set.
REQ-030 release SHALL clear on the read beat carrying M_TLast=1; the remainder of that packet then streams cut-through.
REQ-031 Overrun SHALL stay set until Reset; Flush SHALL NOT clear it.
REQ-032 Flush=1 SHALL clear pointers, Level, PktCount and release on that edge and SHALL take priority over any simultaneous read or write, which are discarded.
REQ-033 M_TData SHALL hold a stable value while M_TValid=1 && M_TReady=0.
REQ-034 Storage SHALL be a WIDTH+1-bit array (data plus last), written synchronously and read asynchronously at the read pointer.

Reset
REQ-035 While Reset=0 at a clock edge: pointers=0, Level=0, PktCount=0, release=0, Overrun=0.
REQ-036 Output reset values SHALL be: isEmpty=1, isFull=0, M_TValid=0, S_TReady=1, AlmostEmpty=1, AlmostFull=0.
REQ-037 Memory contents SHALL NOT be reset; M_TData is don't-care while M_TValid=0.
REQ-038 Reset asserted mid-packet SHALL discard all stored beats, with no partial packet retained.

Structure
REQ-039 A package axis_pkg SHALL hold the beat typedef (data plus last) and the clog2-based width helper constants.
REQ-040 The block SHALL contain one sub-module, fifo_ram, providing the DEPTH x (WIDTH+1) synchronous-write, asynchronous-read array.

Verification
REQ-041 Scenario: DEPTH=8, PKT_MODE=0, write 8 beats (8..1) with M_TReady=0 -> isFull=1, S_TReady=0, Level=8, AlmostFull=1; then M_TReady=1 -> beats read out 8..1 in order, isEmpty=1 after the eighth.
REQ-042 Scenario: PKT_MODE=1, write a 3-beat packet with TLast on beat 3 -> M_TValid stays 0 until the cycle after beat 3, then 3 beats drain and PktCount returns 0.
REQ-043 Scenario: PKT_MODE=1, DEPTH=8, write a 12-beat packet -> at Level=8 release and Overrun set; all 12 beats arrive in order and release clears on the last beat.
REQ-044 Scenario: continuous simultaneous read and write at Level=4 for 20 cycles -> Level stays 4, pointers wrap, data order is preserved.
REQ-045 Scenario: Flush asserted with Level=5 together with S_TValid=1 -> next cycle Level=0, isEmpty=1, and the written beat is discarded.
REQ-046 Scenario: Reset=0 during packet transfer -> all outputs take their REQ-036 values on the next edge, and Overrun=0.
